// File: rtl/pulse_sched.sv
`timescale 1ns/1ps
// Purpose: round-robin owner of one shared fixed-length pulse (PULSE_LEN high, GAP_LEN recovery).
// Latency: req sampled in IDLE -> y_out high the next cycle for PULSE_LEN cycles; ack on last pulse cycle.
// Backpressure: none; req is a level held until ack, a started pulse always runs to completion.
//
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-low reset
//   req[N]        per-requester level request
//   gnt[N]        one-hot owner during PULSE, zero otherwise
//   ack[N]        one-cycle strobe to the owner on the last PULSE cycle
//   owner[IDW]    index of current/last owner
//   y_out, busy   shared pulse (PULSE only); busy in PULSE or GAP
//   state[2]      IDLE=00, PULSE=01, GAP=10
//   err           only with PULSE_SCHED_ERR_EN defined: sticky protocol error flag
module pulse_sched #(
  parameter int N         = 4,
  parameter int IDW       = 2,
  parameter int CW        = 4,
  parameter int PULSE_LEN = 3,
  parameter int GAP_LEN   = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   ack,
  output logic [IDW-1:0] owner,
  output logic           y_out,
  output logic           busy,
  output logic [1:0]     state
`ifdef PULSE_SCHED_ERR_EN
  ,
  output logic           err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_PULSE = 2'b01,
    S_GAP   = 2'b10
  } state_t;

  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_LEN - 1);
  // With GAP_LEN == 0 the GAP state is never entered; keep the constant in range.
  localparam logic [CW-1:0] GAP_LAST   = (GAP_LEN > 0) ? CW'(GAP_LEN - 1) : '0;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [N-1:0]   gnt_q, gnt_d;

  logic           pick_vld;
  logic [IDW-1:0] pick_idx;
  logic [IDW-1:0] scan_idx;
  int             scan;

  function automatic logic [N-1:0] onehot(input logic [IDW-1:0] idx);
    logic [N-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Round-robin pick: scan offsets from high to low so the smallest offset
  // from rr_ptr (the highest-priority candidate) is the last one to win.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan     = 0;
    scan_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      scan     = (int'(rr_ptr_q) + i) % N;
      scan_idx = IDW'(scan);
      if (req[scan_idx]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      gnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      gnt_q    <= gnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    gnt_d    = gnt_q;
    ack      = '0;
    y_out    = 1'b0;
    busy     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          owner_d = pick_idx;
          gnt_d   = onehot(pick_idx);
          cnt_d   = '0;
          state_d = S_PULSE;
        end
      end
      S_PULSE: begin
        y_out = 1'b1;
        busy  = 1'b1;
        if (cnt_q == PULSE_LAST) begin
          ack      = onehot(owner_q);
          rr_ptr_d = (owner_q == IDW'(N - 1)) ? '0 : owner_q + IDW'(1);
          cnt_d    = '0;
          gnt_d    = '0;
          state_d  = (GAP_LEN == 0) ? S_IDLE : S_GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_GAP: begin
        busy = 1'b1;
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        // Unused encoding: recover to IDLE with all outputs low.
        cnt_d   = '0;
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign gnt   = (state_q == S_PULSE) ? gnt_q : '0;
  assign owner = owner_q;
  assign state = state_q;

`ifdef PULSE_SCHED_ERR_EN
  // Sticky: owner withdrew during its pulse, or a grant survived outside PULSE.
  logic err_q;
  logic err_set;

  always_comb begin
    err_set = 1'b0;
    if (state_q == S_PULSE && !req[owner_q]) err_set = 1'b1;
    if (state_q != S_PULSE && gnt_q != '0)   err_set = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_q | err_set;
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_pulse_sched.sv
`timescale 1ns/1ps
// Purpose: self-checking bench for pulse_sched (default timing and a PULSE_LEN=1/GAP_LEN=0 instance).
// Latency: acks are scored against hand-computed cycle numbers pushed when stimulus is issued.
// Backpressure: n/a; requests are held as levels until their ack.
module tb_pulse_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] req2 = '0;

  logic [3:0] gnt, ack, gnt2, ack2;
  logic [1:0] owner, owner2, state, state2;
  logic       y_out, busy, y2, busy2;
`ifdef PULSE_SCHED_ERR_EN
  logic       err, err2;
`endif

  pulse_sched #(.N(4), .IDW(2), .CW(4), .PULSE_LEN(3), .GAP_LEN(2)) u_dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .ack(ack), .owner(owner),
    .y_out(y_out), .busy(busy), .state(state)
`ifdef PULSE_SCHED_ERR_EN
    , .err(err)
`endif
  );

  pulse_sched #(.N(4), .IDW(2), .CW(4), .PULSE_LEN(1), .GAP_LEN(0)) u_fast (
    .clk(clk), .rst(rst), .req(req2), .gnt(gnt2), .ack(ack2), .owner(owner2),
    .y_out(y2), .busy(busy2), .state(state2)
`ifdef PULSE_SCHED_ERR_EN
    , .err(err2)
`endif
  );

  always #5 clk = ~clk;

  // Window number: value of cyc between one rising edge and the next.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] vec;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: every ack the DUT presents must match the next expected entry.
  always @(negedge clk) begin
    if (ack != 4'b0) begin
      if (q1.size() == 0) begin
        chk("ack_unexpected", {28'b0, ack}, 32'h0);
      end else begin
        e1 = q1.pop_front();
        chk("ack_cycle", cyc, e1.cyc);
        chk("ack_vec", {28'b0, ack}, {28'b0, e1.vec});
        chk("ack_gnt", {28'b0, gnt}, {28'b0, e1.vec});
        chk("ack_y_out", {31'b0, y_out}, 32'h1);
      end
    end
  end

  always @(negedge clk) begin
    if (ack2 != 4'b0) begin
      if (q2.size() == 0) begin
        chk("fast_ack_unexpected", {28'b0, ack2}, 32'h0);
      end else begin
        e2 = q2.pop_front();
        chk("fast_ack_cycle", cyc, e2.cyc);
        chk("fast_ack_vec", {28'b0, ack2}, {28'b0, e2.vec});
      end
    end
  end

  int t1_st[7] = '{0, 1, 1, 1, 2, 2, 0};
  int w;
  logic [3:0] eg;
  logic       ey;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", {30'b0, state}, 32'h0);
    chk("rst_gnt", {28'b0, gnt}, 32'h0);
    chk("rst_ack", {28'b0, ack}, 32'h0);
    chk("rst_owner", {30'b0, owner}, 32'h0);
    chk("rst_y_out", {31'b0, y_out}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
`ifdef PULSE_SCHED_ERR_EN
    chk("rst_err", {31'b0, err}, 32'h0);
`endif
    nxt();
    rst = 1'b1;
    nxt();
    nxt();

    // Single request from requester 0
    w = cyc;
    req = 4'b0001;
    q1.push_back('{w + 3, 4'b0001});
    for (int k = 0; k < 7; k++) begin
      if (k == 4) req = 4'b0000;
      @(negedge clk);
      chk("single_state", {30'b0, state}, t1_st[k]);
      chk("single_y_out", {31'b0, y_out}, (t1_st[k] == 1) ? 32'h1 : 32'h0);
      chk("single_busy", {31'b0, busy}, (t1_st[k] != 0) ? 32'h1 : 32'h0);
      chk("single_gnt", {28'b0, gnt}, (t1_st[k] == 1) ? 32'h1 : 32'h0);
      nxt();
    end
    chk("single_owner", {30'b0, owner}, 32'h0);

    // Reset mid-pulse: rr_ptr is 1, so requester 2 is granted, then aborted
    req = 4'b0100;
    nxt();
    @(negedge clk);
    chk("rr_from_ptr_gnt", {28'b0, gnt}, 32'h4);
    chk("rr_from_ptr_owner", {30'b0, owner}, 32'h2);
    nxt();
    rst = 1'b0;
    req = 4'b0000;
    #1;
    chk("abort_y_out", {31'b0, y_out}, 32'h0);
    chk("abort_gnt", {28'b0, gnt}, 32'h0);
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_state", {30'b0, state}, 32'h0);
    chk("abort_ack", {28'b0, ack}, 32'h0);
    nxt();

    // Contention 0101 after reset: grants 0,2,0,2, pulse starts 6 cycles apart
    rst = 1'b1;
    w = cyc;
    req = 4'b0101;
    for (int i = 0; i < 4; i++)
      q1.push_back('{w + 3 + 6 * i, (i % 2 == 0) ? 4'b0001 : 4'b0100});
    for (int k = 0; k < 25; k++) begin
      if (k == 22) req = 4'b0000;
      ey = (k >= 1 && k <= 21 && ((k - 1) % 6) < 3);
      @(negedge clk);
      chk("contend_y_out", {31'b0, y_out}, {31'b0, ey});
      nxt();
    end

    // Fairness: req[1] held, req[3] raised mid-pulse of 1 -> 1, 3, 1
    w = cyc;
    req = 4'b0010;
    q1.push_back('{w + 3, 4'b0010});
    q1.push_back('{w + 9, 4'b1000});
    q1.push_back('{w + 15, 4'b0010});
    for (int k = 0; k < 19; k++) begin
      if (k == 2)  req[3] = 1'b1;
      if (k == 10) req[3] = 1'b0;
      if (k == 16) req = 4'b0000;
      if (k >= 1 && k <= 3)        eg = 4'b0010;
      else if (k >= 7 && k <= 9)   eg = 4'b1000;
      else if (k >= 13 && k <= 15) eg = 4'b0010;
      else                         eg = 4'b0000;
      @(negedge clk);
      chk("fair_gnt", {28'b0, gnt}, {28'b0, eg});
      nxt();
    end

    // Withdrawal: rr_ptr is 2, req 0001 wins; owner drops req in 2nd pulse cycle
    w = cyc;
    req = 4'b0001;
    q1.push_back('{w + 3, 4'b0001});
    for (int k = 0; k < 7; k++) begin
      if (k == 2) req = 4'b0000;
      @(negedge clk);
      chk("withdraw_y_out", {31'b0, y_out}, (k >= 1 && k <= 3) ? 32'h1 : 32'h0);
`ifdef PULSE_SCHED_ERR_EN
      chk("withdraw_err", {31'b0, err}, (k >= 3) ? 32'h1 : 32'h0);
`endif
      nxt();
    end
    rst = 1'b0;
    #1;
`ifdef PULSE_SCHED_ERR_EN
    chk("err_cleared", {31'b0, err}, 32'h0);
`endif
    chk("rst2_busy", {31'b0, busy}, 32'h0);
    nxt();
    rst = 1'b1;
    nxt();

    // PULSE_LEN=1, GAP_LEN=0: pulse every 2nd cycle with coincident ack
    w = cyc;
    req2 = 4'b0010;
    for (int i = 0; i < 3; i++) q2.push_back('{w + 1 + 2 * i, 4'b0010});
    for (int k = 0; k < 8; k++) begin
      if (k == 6) req2 = 4'b0000;
      ey = (k % 2 == 1) && (k <= 5);
      @(negedge clk);
      chk("fast_y_out", {31'b0, y2}, {31'b0, ey});
      chk("fast_busy", {31'b0, busy2}, {31'b0, ey});
      chk("fast_ack", {28'b0, ack2}, ey ? 32'h2 : 32'h0);
      nxt();
    end

    repeat (3) nxt();
    chk("sb_drained", q1.size(), 32'h0);
    chk("fast_sb_drained", q2.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
